screen_page_sequencer: RTL and testbench

//  Top-level page/flow controller between game_logic, page renderers and vga_ctrl.

---
 rtl/screen_page_sequencer.sv | 76 +++++++
 tb/tb_screen_page_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/screen_page_sequencer.sv
// screen_page_sequencer: frame-synchronous START/PLAY/OVER/WON page flow, game control and page pixel mux
//   vga_clk, reset                  : pixel clock, synchronous active-high reset
//   frame_tick                      : one pulse per frame; all page changes commit on it
//   key_any                         : OR of direction keys (synchronised level)
//   game_over, game_won, score_in   : status from game_logic
//   start_rgb, game_rgb, end_rgb    : page pixels in
//   pix_data                        : selected pixel (1-cycle latency)
//   page                            : 00 START, 01 PLAY, 10 OVER, 11 WON
//   game_reset, game_run            : game_logic control
//   score_latched                   : score captured when leaving PLAY
module screen_page_sequencer #(
  parameter int RGB_W = 16,
  parameter int SCORE_W = 8,
  parameter int OVER_HOLD_FRAMES = 120
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               key_any,
  input  logic               game_over,
  input  logic               game_won,
  input  logic [SCORE_W-1:0] score_in,
  input  logic [RGB_W-1:0]   start_rgb,
  input  logic [RGB_W-1:0]   game_rgb,
  input  logic [RGB_W-1:0]   end_rgb,
  output logic [RGB_W-1:0]   pix_data,
  output logic [1:0]         page,
  output logic               game_reset,
  output logic               game_run,
  output logic [SCORE_W-1:0] score_latched
);
  localparam int HW = $clog2(OVER_HOLD_FRAMES + 1);
  localparam logic [1:0] START = 2'b00, PLAY = 2'b01, OVER = 2'b10, WON = 2'b11;
  logic [1:0] state, next;
  logic [HW-1:0] hold_cnt;
  logic start_req, key_q, key_rise, saturated, press, next_reset, next_run;
  assign key_rise = key_any & ~key_q;
  assign saturated = hold_cnt == HW'(OVER_HOLD_FRAMES);
  // a rise on the tick cycle counts as already seen
  assign press = start_req | key_rise;
  assign page = state;
  always_comb begin
    next = !frame_tick ? state :
           state == START ? (press ? PLAY : START) :
           state == PLAY ? (game_won ? WON : game_over ? OVER : PLAY) :
           (saturated && press) ? START : state;
  end
  always_comb begin
    next_reset = next == START;
    next_run = next == PLAY;
  end
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state <= START;
      game_reset <= 1'b1;
      game_run <= 1'b0;
      pix_data <= '0;
      score_latched <= '0;
      hold_cnt <= '0;
      start_req <= 1'b0;
      key_q <= 1'b1;
    end else begin
      state <= next;
      game_reset <= next_reset;
      game_run <= next_run;
      key_q <= key_any;
      pix_data <= state == START ? start_rgb : state == PLAY ? game_rgb : end_rgb;
      if (state == PLAY && next != PLAY) score_latched <= score_in;
      hold_cnt <= state == PLAY ? '0 :
                  (state[1] && frame_tick && !saturated) ? hold_cnt + 1'b1 : hold_cnt;
      // presses on the end pages before saturation are dropped, not queued
      start_req <= next != state ? 1'b0 :
                   (key_rise && (state == START || (state[1] && saturated))) ? 1'b1 : start_req;
    end
  end
endmodule

// File: tb/tb_screen_page_sequencer.sv
// tb_screen_page_sequencer: directed flow checks plus a pixel scoreboard for screen_page_sequencer
module tb_screen_page_sequencer;
  logic vga_clk = 1'b0, reset = 1'b1, frame_tick = 1'b0, key_any = 1'b1;
  logic game_over = 1'b0, game_won = 1'b0, rand_pix = 1'b1;
  logic [7:0] score_in = '0, score_latched;
  logic [15:0] start_rgb = '0, game_rgb = '0, end_rgb = '0, pix_data;
  logic [1:0] page, exp_page = 2'b00;
  logic game_reset, game_run;
  logic [15:0] sb[$];
  int n_chk = 0, n_fail = 0;

  screen_page_sequencer dut (
    .vga_clk(vga_clk), .reset(reset), .frame_tick(frame_tick), .key_any(key_any),
    .game_over(game_over), .game_won(game_won), .score_in(score_in),
    .start_rgb(start_rgb), .game_rgb(game_rgb), .end_rgb(end_rgb),
    .pix_data(pix_data), .page(page), .game_reset(game_reset), .game_run(game_run),
    .score_latched(score_latched)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge vga_clk) begin
    if (rand_pix) begin
      start_rgb = 16'($urandom);
      game_rgb = 16'($urandom);
      end_rgb = 16'($urandom);
    end else begin
      start_rgb = 16'h001F;
      game_rgb = 16'hF800;
      end_rgb = 16'h07E0;
    end
    if (sb.size() > 0) chk("pix", 32'(pix_data), 32'(sb.pop_front()));
  end

  always @(posedge vga_clk)
    sb.push_back(reset ? 16'h0 : exp_page == 2'b00 ? start_rgb : exp_page == 2'b01 ? game_rgb : end_rgb);

  task automatic cyc();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic ctl_chk(input string tag);
    chk({tag, "_page"}, 32'(page), 32'(exp_page));
    chk({tag, "_reset"}, 32'(game_reset), 32'(exp_page == 2'b00));
    chk({tag, "_run"}, 32'(game_run), 32'(exp_page == 2'b01));
  endtask

  task automatic frame(input logic [1:0] np, input string tag);
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    exp_page = np;
    ctl_chk(tag);
    cyc();
  endtask

  task automatic press();
    key_any = 1'b1;
    cyc();
    key_any = 1'b0;
    cyc();
  endtask

  initial begin
    repeat (3) cyc();
    ctl_chk("rst");
    chk("rst_score", 32'(score_latched), 0);
    reset = 1'b0;
    cyc();
    repeat (3) frame(2'b00, "held_key");
    key_any = 1'b0;
    cyc();
    press();
    ctl_chk("no_tick");
    frame(2'b01, "start_play");
    rand_pix = 1'b0;
    cyc();
    cyc();
    chk("pix_play", 32'(pix_data), 32'h0000F800);
    rand_pix = 1'b1;
    score_in = 8'd37;
    game_over = 1'b1;
    repeat (3) cyc();
    ctl_chk("over_wait");
    frame(2'b10, "over");
    chk("score37", 32'(score_latched), 37);
    score_in = 8'd99;
    for (int i = 1; i <= 120; i++) begin
      if (i == 50 || i == 120) press();
      frame(2'b10, "hold");
    end
    chk("score_stable", 32'(score_latched), 37);
    frame(2'b10, "no_queue");
    game_over = 1'b0;
    press();
    frame(2'b00, "restart");
    frame(2'b00, "need_new_key");
    press();
    frame(2'b01, "replay");
    cyc();
    reset = 1'b1;
    cyc();
    exp_page = 2'b00;
    ctl_chk("mid_rst");
    chk("mid_rst_score", 32'(score_latched), 0);
    chk("mid_rst_pix", 32'(pix_data), 0);
    reset = 1'b0;
    cyc();
    press();
    frame(2'b01, "play2");
    score_in = 8'd5;
    game_won = 1'b1;
    game_over = 1'b1;
    cyc();
    frame(2'b11, "won");
    chk("score5", 32'(score_latched), 5);
    game_won = 1'b0;
    game_over = 1'b0;
    press();
    frame(2'b11, "won_hold");
    repeat (3) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
